ram_fifo_ctrl: RTL

- Controller stage directly upstream of the single-port RAM_RW memory (SEL=1 write, SEL=0 read, registered Dout, one-cycle read latency).
- Turns RAM_RW into a FIFO: accepts words on a valid/ready input, writes them into RAM, prefetches them back, and presents them on a valid/ready output.
- Drives the RAM's SEL/addr/Din and consumes its Dout. Only one RAM access (read or write) is issued per cycle.

---
 rtl/ram_fifo_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM with a one-cycle registered read.
// Words are written into RAM, prefetched into an output register and handed off over valid/ready.
module ram_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  ram_sel,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  w_not_empty;
  logic                  w_not_full;
  logic                  w_rd_go;
  logic                  w_wr_go;

  assign w_not_empty = (r_count != CNT_W'(0));
  assign w_not_full  = (r_count < CNT_W'(DEPTH));

  // Read issue and next state: a read is launched whenever the output register will be free.
  always_comb begin
    w_rd_go      = 1'b0;
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_not_empty) begin
          w_rd_go      = 1'b1;
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        w_next_state = VALID;
      end
      VALID: begin
        if (out_ready) begin
          if (w_not_empty) begin
            w_rd_go      = 1'b1;
            w_next_state = FETCH;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Write issue: reads own the RAM port, so writes only slot into non-read cycles.
  always_comb begin
    in_ready = 1'b0;
    w_wr_go  = 1'b0;
    ram_sel  = 1'b0;
    ram_addr = r_rd_ptr;
    in_ready = !reset && !w_rd_go && w_not_full;
    w_wr_go  = in_valid && in_ready;
    if (w_wr_go) begin
      ram_sel  = 1'b1;
      ram_addr = r_wr_ptr;
    end
  end

  assign ram_din   = in_data;
  assign out_valid = (r_state == VALID);
  assign out_data  = r_out_data;
  assign level     = r_count + CNT_W'(out_valid);

  // Pointers, occupancy and output capture; read and write never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out_data <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_rd_go) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
        r_count  <= r_count - CNT_W'(1);
      end else if (w_wr_go) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
        r_count  <= r_count + CNT_W'(1);
      end
      if (r_state == FETCH) begin
        r_out_data <= ram_dout;
      end
    end
  end

endmodule
